// File: rtl/sobel_pkg.sv
// Shared image geometry, BMP row padding helper and streamer FSM states for the
// BMP -> grayscale -> Sobel pipeline.
package sobel_pkg;

    localparam int IMG_WIDTH_DEF  = 640;
    localparam int IMG_HEIGHT_DEF = 480;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PIX  = 2'd1,
        PAD  = 2'd2,
        FIN  = 2'd3
    } bmp_state_t;

    // BMP rows are padded to a multiple of 4 bytes.
    function automatic int row_pad(input int width);
        return (4 - ((3 * width) % 4)) % 4;
    endfunction

    // Counter width for a limit; never below 1 bit so degenerate sizes still elaborate.
    function automatic int cnt_w(input int limit);
        return (limit > 1) ? $clog2(limit) : 1;
    endfunction

endpackage

// File: rtl/bmp_pos_counter.sv
// Column, row and row-pad position counters for the BMP pixel streamer.
module bmp_pos_counter
    import sobel_pkg::*;
#(
    parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
    parameter int IMG_HEIGHT = IMG_HEIGHT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic pix_step,
    input  logic pad_step,
    output logic row_end,
    output logic frame_end,
    output logic pad_end
);

    localparam int ROW_PAD = row_pad(IMG_WIDTH);
    localparam int COL_W   = cnt_w(IMG_WIDTH);
    localparam int ROW_W   = cnt_w(IMG_HEIGHT);
    localparam int PAD_W   = cnt_w(ROW_PAD);

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic [PAD_W-1:0] pad;
    logic             row_adv;

    assign row_end   = (col == COL_W'(IMG_WIDTH - 1));
    assign frame_end = (row == ROW_W'(IMG_HEIGHT - 1));
    assign pad_end   = (ROW_PAD != 0) && (pad == PAD_W'(ROW_PAD - 1));

    // Without padding the row turns over on the last pixel, otherwise on the last pad byte.
    assign row_adv = (pix_step && row_end && (ROW_PAD == 0)) || (pad_step && pad_end);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col <= '0;
            row <= '0;
            pad <= '0;
        end else if (clear) begin
            col <= '0;
            row <= '0;
            pad <= '0;
        end else begin
            if (pix_step) col <= row_end ? '0 : col + 1'b1;
            if (pad_step) pad <= pad_end ? '0 : pad + 1'b1;
            if (row_adv)  row <= frame_end ? '0 : row + 1'b1;
        end
    end

endmodule

// File: rtl/bmp_pixel_streamer.sv
// Assembles B,G,R bytes of a BMP pixel array into RGB pixels, skipping row padding,
// and strobes done_o per pixel and frame_done_o at the end of the frame.
module bmp_pixel_streamer
    import sobel_pkg::*;
#(
    parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
    parameter int IMG_HEIGHT = IMG_HEIGHT_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic [7:0] byte_i,
    input  logic       byte_valid_i,
    output logic       byte_ready_o,
    output logic [7:0] red_o,
    output logic [7:0] green_o,
    output logic [7:0] blue_o,
    output logic       done_o,
    output logic       frame_done_o,
    output logic       busy_o
);

    localparam int ROW_PAD = row_pad(IMG_WIDTH);

    bmp_state_t state, state_nx;
    logic [1:0] phase;
    logic [7:0] b_acc, g_acc;
    logic       accept, pix_done, pad_acc, clear;
    logic       row_end, frame_end, pad_end;

    assign byte_ready_o = (state == PIX) || (state == PAD);
    assign busy_o       = (state != IDLE);
    assign frame_done_o = (state == FIN);

    assign accept   = byte_valid_i && byte_ready_o;
    assign pix_done = accept && (state == PIX) && (phase == 2'd2);
    assign pad_acc  = accept && (state == PAD);
    assign clear    = (state == IDLE) && start_i;

    bmp_pos_counter #(
        .IMG_WIDTH (IMG_WIDTH),
        .IMG_HEIGHT(IMG_HEIGHT)
    ) u_pos (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .pix_step (pix_done),
        .pad_step (pad_acc),
        .row_end  (row_end),
        .frame_end(frame_end),
        .pad_end  (pad_end)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (start_i) state_nx = PIX;
            PIX: begin
                if (pix_done && row_end) begin
                    if (ROW_PAD != 0)   state_nx = PAD;
                    else if (frame_end) state_nx = FIN;
                end
            end
            PAD: if (pad_acc && pad_end) state_nx = frame_end ? FIN : PIX;
            FIN: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Partial bytes live in b_acc/g_acc so the outputs only change on a complete pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase   <= '0;
            b_acc   <= '0;
            g_acc   <= '0;
            red_o   <= '0;
            green_o <= '0;
            blue_o  <= '0;
            done_o  <= 1'b0;
        end else begin
            done_o <= pix_done;
            if (clear) begin
                phase <= '0;
            end else if (accept && (state == PIX)) begin
                case (phase)
                    2'd0: begin
                        b_acc <= byte_i;
                        phase <= 2'd1;
                    end
                    2'd1: begin
                        g_acc <= byte_i;
                        phase <= 2'd2;
                    end
                    2'd2: begin
                        red_o   <= byte_i;
                        green_o <= g_acc;
                        blue_o  <= b_acc;
                        phase   <= 2'd0;
                    end
                    default: phase <= 2'd0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bmp_pixel_streamer.sv
// Bench for bmp_pixel_streamer: three geometries (2x1 padded, 4x2 unpadded, 3x2 padded)
// checked cycle by cycle against a byte-index model of the BMP layout.
`timescale 1ns/1ps
module tb_bmp_pixel_streamer;

    logic       clk = 1'b0;
    logic       rst;
    logic       st [3];
    logic       vl [3];
    logic [7:0] by [3];
    logic       rdy [3];
    logic [7:0] r [3];
    logic [7:0] g [3];
    logic [7:0] b [3];
    logic       dn [3];
    logic       fd [3];
    logic       bsy [3];

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  stream [$];
    logic [23:0] got [$];
    logic [23:0] exp_hold [3];

    always #5 clk = ~clk;

    bmp_pixel_streamer #(.IMG_WIDTH(2), .IMG_HEIGHT(1)) u_a (
        .clk(clk), .rst(rst), .start_i(st[0]), .byte_i(by[0]), .byte_valid_i(vl[0]),
        .byte_ready_o(rdy[0]), .red_o(r[0]), .green_o(g[0]), .blue_o(b[0]),
        .done_o(dn[0]), .frame_done_o(fd[0]), .busy_o(bsy[0]));

    bmp_pixel_streamer #(.IMG_WIDTH(4), .IMG_HEIGHT(2)) u_b (
        .clk(clk), .rst(rst), .start_i(st[1]), .byte_i(by[1]), .byte_valid_i(vl[1]),
        .byte_ready_o(rdy[1]), .red_o(r[1]), .green_o(g[1]), .blue_o(b[1]),
        .done_o(dn[1]), .frame_done_o(fd[1]), .busy_o(bsy[1]));

    bmp_pixel_streamer #(.IMG_WIDTH(3), .IMG_HEIGHT(2)) u_c (
        .clk(clk), .rst(rst), .start_i(st[2]), .byte_i(by[2]), .byte_valid_i(vl[2]),
        .byte_ready_o(rdy[2]), .red_o(r[2]), .green_o(g[2]), .blue_o(b[2]),
        .done_o(dn[2]), .frame_done_o(fd[2]), .busy_o(bsy[2]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_chk(input int k);
        check($sformatf("idle_busy%0d", k),  {31'd0, bsy[k]}, 32'd0);
        check($sformatf("idle_ready%0d", k), {31'd0, rdy[k]}, 32'd0);
        check($sformatf("idle_done%0d", k),  {31'd0, dn[k]},  32'd0);
        check($sformatf("idle_fdone%0d", k), {31'd0, fd[k]},  32'd0);
        check($sformatf("idle_rgb%0d", k),   {8'd0, r[k], g[k], b[k]}, {8'd0, exp_hold[k]});
    endtask

    task automatic fill_random(input int n);
        stream.delete();
        for (int i = 0; i < n; i++) stream.push_back(8'($urandom));
    endtask

    // mode 0: back-to-back, 1: random gaps, 2: valid every other cycle.
    // Expected behaviour comes from the index of each accepted byte in the file layout.
    task automatic run_frame(input int k, input int w, input int h, input int mode, input bit rnd_start);
        int stride, total, idx, prev_j, pos, budget;
        bit prev_acc, exp_dn, exp_fd, v, seen_fd;
        stride = ((3 * w + 3) / 4) * 4;
        total  = stride * h;
        got.delete();
        st[k] = 1'b1;
        @(negedge clk);
        st[k] = 1'b0;
        idx = 0; prev_j = 0; prev_acc = 0; seen_fd = 0; budget = 0;
        while (!seen_fd && budget < 4000) begin
            exp_dn = 0; exp_fd = 0;
            if (prev_acc) begin
                pos    = prev_j % stride;
                exp_dn = (pos < 3 * w) && (pos % 3 == 2);
                exp_fd = (prev_j == total - 1);
            end
            if (exp_dn) begin
                exp_hold[k] = {stream[prev_j], stream[prev_j - 1], stream[prev_j - 2]};
                got.push_back({r[k], g[k], b[k]});
            end
            check($sformatf("done%0d", k),  {31'd0, dn[k]},  {31'd0, exp_dn});
            check($sformatf("fdone%0d", k), {31'd0, fd[k]},  {31'd0, exp_fd});
            check($sformatf("rgb%0d", k),   {8'd0, r[k], g[k], b[k]}, {8'd0, exp_hold[k]});
            check($sformatf("busy%0d", k),  {31'd0, bsy[k]}, 32'd1);
            check($sformatf("ready%0d", k), {31'd0, rdy[k]}, {31'd0, !exp_fd});
            seen_fd = exp_fd || fd[k];
            if (!seen_fd) begin
                case (mode)
                    0:       v = 1'b1;
                    2:       v = (budget % 2 == 0);
                    default: v = ($urandom_range(0, 99) < 60);
                endcase
                v = v && (idx < total);
                vl[k] = v;
                by[k] = v ? stream[idx] : 8'($urandom);
                st[k] = rnd_start && ($urandom_range(0, 9) == 0);
                prev_acc = v && rdy[k];
                prev_j   = idx;
                if (prev_acc) idx++;
                @(negedge clk);
                budget++;
            end
        end
        check($sformatf("frame_seen%0d", k), {31'd0, seen_fd}, 32'd1);
        vl[k] = 1'b0;
        st[k] = 1'b0;
        @(negedge clk);
        idle_chk(k);
    endtask

    initial begin
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            st[k] = 1'b0; vl[k] = 1'b0; by[k] = 8'h00; exp_hold[k] = 24'h0;
        end
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) idle_chk(k);
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) idle_chk(k);

        // 2x1 frame with two pad bytes, back-to-back
        stream = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'hAA, 8'hBB};
        run_frame(0, 2, 1, 0, 1'b0);
        check("a_npix", got.size(), 32'd2);
        if (got.size() == 2) begin
            check("a_pix0", {8'd0, got[0]}, 32'h302010);
            check("a_pix1", {8'd0, got[1]}, 32'h605040);
        end

        // same frame with valid toggling
        run_frame(0, 2, 1, 2, 1'b0);
        check("a_tog_npix", got.size(), 32'd2);
        if (got.size() == 2) begin
            check("a_tog_pix0", {8'd0, got[0]}, 32'h302010);
            check("a_tog_pix1", {8'd0, got[1]}, 32'h605040);
        end

        // reset after two bytes of pixel 0
        st[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0; vl[0] = 1'b1; by[0] = 8'h77;
        @(negedge clk);
        by[0] = 8'h88;
        @(negedge clk);
        vl[0] = 1'b0;
        rst = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            exp_hold[k] = 24'h0;
            idle_chk(k);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        idle_chk(0);
        stream = '{8'h10, 8'h20, 8'h30, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        run_frame(0, 2, 1, 0, 1'b0);
        if (got.size() > 0) check("rst_restart_pix0", {8'd0, got[0]}, 32'h302010);

        // bytes offered in IDLE are ignored
        for (int i = 0; i < 5; i++) begin
            vl[1] = 1'b1;
            by[1] = 8'($urandom);
            @(negedge clk);
            idle_chk(1);
        end
        vl[1] = 1'b0;

        // 4x2, no padding: done every third cycle, frame_done with the last pixel
        fill_random(24);
        run_frame(1, 4, 2, 0, 1'b0);
        check("b_npix", got.size(), 32'd8);
        fill_random(24);
        run_frame(1, 4, 2, 1, 1'b1);
        check("b_rnd_npix", got.size(), 32'd8);

        // 3x2 with three pad bytes per row, random gaps and stray starts
        for (int f = 0; f < 4; f++) begin
            fill_random(24);
            run_frame(2, 3, 2, 1, 1'b1);
            check("c_npix", got.size(), 32'd6);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
